// File: rtl/dcache_wb_if.sv
// Bundle of the cache's datapath-side and memory-side signals.
// The cache is the slave; the environment (datapath + memory) is the master.
interface dcache_wb_if;
  // MEM-stage request side
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  // memory-control side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, one-word-block data cache.
// Misses write back a dirty victim (WB) and then fetch the new word (ALLOC);
// halt walks every frame writing back dirty ones (FLUSH) and parks in DONE.
module dcache_wb #(
  parameter int SETS  = 16,
  parameter int TAG_W = 30 - $clog2(SETS)
) (
  input logic        CLK,
  input logic        nRST,
  dcache_wb_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [2:0] {IDLE, WB, ALLOC, FLUSH, DONE} state_t;

  state_t             state_q, state_d;
  logic [SETS-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        data_q [SETS];
  logic [IDX_W-1:0]   fidx_q;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req, hit;
  logic               wr_hit, wb_done, alloc_done, flush_start, flush_adv;
  logic               unused_byte_off;

  assign req_idx = bus.dmemaddr[IDX_W+1:2];
  assign req_tag = bus.dmemaddr[31:IDX_W+2];
  assign req     = bus.dmemREN | bus.dmemWEN;
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // Byte offset within the word plays no part in lookup.
  assign unused_byte_off = ^bus.dmemaddr[1:0];

  // Next-state, bus outputs and frame-update strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d       = state_q;
    bus.dhit      = 1'b0;
    bus.dmemload  = '0;
    bus.flushed   = 1'b0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    wr_hit        = 1'b0;
    wb_done       = 1'b0;
    alloc_done    = 1'b0;
    flush_start   = 1'b0;
    flush_adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d     = FLUSH;
          flush_start = 1'b1;
        end else if (req) begin
          if (hit) begin
            bus.dhit = 1'b1;
            wr_hit   = bus.dmemWEN;
            if (!bus.dmemWEN) bus.dmemload = data_q[req_idx];
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WB;
          end else begin
            state_d = ALLOC;
          end
        end
      end
      WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tag_q[req_idx], req_idx, 2'b00};
        bus.dstore = data_q[req_idx];
        if (!bus.dwait) begin
          wb_done = 1'b1;
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        bus.dREN  = 1'b1;
        bus.daddr = {bus.dmemaddr[31:2], 2'b00};
        if (!bus.dwait) begin
          alloc_done = 1'b1;
          state_d    = IDLE;
        end
      end
      FLUSH: begin
        if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
          bus.dWEN   = 1'b1;
          bus.daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
          bus.dstore = data_q[fidx_q];
          flush_adv  = !bus.dwait;
        end else begin
          flush_adv  = 1'b1;
        end
        if (flush_adv && (fidx_q == IDX_W'(SETS - 1))) state_d = DONE;
      end
      DONE: begin
        bus.flushed = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flush walker and per-frame valid/dirty bits.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) begin
      state_q <= IDLE;
      fidx_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_start)    fidx_q <= '0;
      else if (flush_adv) fidx_q <= fidx_q + IDX_W'(1);
      if (wr_hit)  dirty_q[req_idx] <= 1'b1;
      if (wb_done) dirty_q[req_idx] <= 1'b0;
      if (alloc_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (flush_adv) dirty_q[fidx_q] <= 1'b0;
    end
  end

  // Tag and data arrays.
  // NOTE: no reset on the arrays; a frame's contents are ignored until its valid bit is set.
  always_ff @(posedge CLK) begin
    if (wr_hit) begin
      data_q[req_idx] <= bus.dmemstore;
    end else if (alloc_done) begin
      data_q[req_idx] <= bus.dload;
      tag_q[req_idx]  <= req_tag;
    end
  end
endmodule
